gf8_inv_pipe: RTL and testbench
===============================

GF8_INV_PIPE -- requirements
Module: gf8_inv_pipe

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of the completed-result counter.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port clear  input  1  synchronous flush of all pipeline contents and the counter.
REQ-005 SHALL have port in_valid  input  1  in_data holds a byte to process.
REQ-006 SHALL have port in_ready  output  1  block accepts in_data this cycle.
REQ-007 SHALL have port in_data  input  8  GF(2^8) element, polynomial basis, x^8+x^4+x^3+x+1.
REQ-008 SHALL have port out_valid  output  1  out_data holds a result.
REQ-009 SHALL have port out_ready  input  1  consumer takes out_data this cycle.
REQ-010 SHALL have port out_data  output  8  result byte, polynomial basis.
REQ-011 SHALL have port out_count  output  CNT_W  number of completed output handshakes, modulo 2^CNT_W.

Function
REQ-012 SHALL accept a byte when in_valid & in_ready, and deliver its result when out_valid & out_ready.
REQ-013 SHALL compute the multiplicative inverse in GF(2^8) through the composite field GF(((2^2)^2)^2).
- S1: map to composite basis; form nibble D = f(Ah, Al).
- S2: 4-bit inverse E = D^-1 in GF((2^2)^2), with 0 -> 0.
- S3: multiply E by Ah and Al; map back to polynomial basis.
REQ-014 SHALL hold each stage in a register (S1, S2, S3), each with its own valid bit; out_valid = S3 valid.
REQ-015 SHALL have a latency of exactly 3 cycles from the input handshake to out_valid, with no stalls.
REQ-016 SHALL sustain one byte per cycle while out_ready is held high.
REQ-017 SHALL advance stage k only if it is empty or stage k+1 advances this cycle; in_ready = S1 may advance.
REQ-018 SHALL make in_ready depend combinationally on out_ready; in_ready SHALL NOT depend on in_valid.
REQ-019 SHALL hold out_data and out_valid stable while out_valid=1 and out_ready=0; no result is dropped or duplicated.
REQ-020 SHALL map input 0x00 to output 0x00 when the affine step is absent.
REQ-021 SHALL preserve input order in the output; all 3 stages may be full at once.
REQ-022 SHALL increment out_count by 1 per output handshake and wrap from all-ones to 0.
REQ-023 SHALL give clear priority over any simultaneous handshake: next cycle all valid bits = 0 and out_count = 0; an input offered in the clear cycle is discarded.
REQ-024 SHALL drive in_ready=1 in the cycle after clear.

Reset
REQ-025 SHALL, while reset_n=0, immediately force all stage valid bits to 0, out_valid=0, out_data=0x00 and out_count=0, independent of clk.
REQ-026 SHALL, on reset mid-operation, discard all in-flight bytes; no result from before reset appears afterwards.
REQ-027 SHALL have in_ready=1 on the first rising clk edge after reset_n deasserts.
REQ-028 SHALL leave data registers without reset, except the S3 data register (reset to 0x00).

Configuration
REQ-029 SHALL, with macro SBOX_AFFINE_EN defined, apply the AES forward affine transform in S3, so out_data = AES S-box(in_data), e.g. 0x00 -> 0x63.
REQ-030 SHALL, without SBOX_AFFINE_EN, output the plain inverse; latency and handshake SHALL be identical in both builds.

Verification
REQ-031 SHALL cover: reset, then in 0x53 with out_ready=1 -> out_valid at handshake+3, out_data 0xCA (0xED with SBOX_AFFINE_EN), out_count=1.
REQ-032 SHALL cover: stream 0x00, 0x01, 0x53, 0xCA back-to-back, out_ready=1 -> 0x00, 0x01, 0xCA, 0x53 on consecutive cycles (affine build: 0x63, 0x7C, 0xED, 0x74).
REQ-033 SHALL cover: out_ready=0, offer 5 bytes -> exactly 3 accepted, then in_ready=0; raise out_ready -> 3 results in order, no loss.
REQ-034 SHALL cover: clear asserted with 3 bytes in flight and in_valid=1 -> next cycle out_valid=0, out_count=0, no stale output afterwards.
REQ-035 SHALL cover: CNT_W=4, 17 handshakes -> out_count reads 1.
REQ-036 SHALL cover: exhaustive 0x00-0xFF with random out_ready -> every out_data matches the reference inverse/S-box table, in order.

Source files
------------

// File: rtl/gf8_inv_pipe.sv
// gf8_inv_pipe: 3-stage GF(2^8) multiplicative inverter using the GF(((2^2)^2)^2) tower field.
// Define SBOX_AFFINE_EN to append the AES forward affine step in S3 (full AES S-box).
module gf8_inv_pipe #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic [CNT_W-1:0] out_count
);
    // Tower: GF(4)=GF(2)[w]/(w^2+w+1), GF(16)=GF(4)[y]/(y^2+y+PHI), GF(256)=GF(16)[z]/(z^2+z+LAMBDA)
    localparam logic [1:0] PHI    = 2'b10;
    localparam logic [3:0] LAMBDA = 4'b1000;

    function automatic logic [1:0] gf4_mul(input logic [1:0] a, input logic [1:0] b);
        return {(a[1] & b[1]) ^ (a[1] & b[0]) ^ (a[0] & b[1]),
                (a[1] & b[1]) ^ (a[0] & b[0])};
    endfunction

    function automatic logic [1:0] gf4_sq(input logic [1:0] a);
        return {a[1], a[1] ^ a[0]};
    endfunction

    function automatic logic [3:0] gf16_mul(input logic [3:0] a, input logic [3:0] b);
        logic [1:0] hh, hl, lh, ll;
        hh = gf4_mul(a[3:2], b[3:2]);
        hl = gf4_mul(a[3:2], b[1:0]);
        lh = gf4_mul(a[1:0], b[3:2]);
        ll = gf4_mul(a[1:0], b[1:0]);
        return {hh ^ hl ^ lh, gf4_mul(hh, PHI) ^ ll};
    endfunction

    // In GF(4) the inverse equals the square, and 0 maps to 0 for free.
    function automatic logic [3:0] gf16_inv(input logic [3:0] a);
        logic [1:0] n, ni;
        n  = gf4_mul(gf4_sq(a[3:2]), PHI) ^ gf4_mul(a[3:2], a[1:0]) ^ gf4_sq(a[1:0]);
        ni = gf4_sq(n);
        return {gf4_mul(a[3:2], ni), gf4_mul(a[3:2] ^ a[1:0], ni)};
    endfunction

    function automatic logic [7:0] gfc_mul(input logic [7:0] a, input logic [7:0] b);
        logic [3:0] hh, hl, lh, ll;
        hh = gf16_mul(a[7:4], b[7:4]);
        hl = gf16_mul(a[7:4], b[3:0]);
        lh = gf16_mul(a[3:0], b[7:4]);
        ll = gf16_mul(a[3:0], b[3:0]);
        return {hh ^ hl ^ lh, gf16_mul(hh, LAMBDA) ^ ll};
    endfunction

    // Column j of m is the image of basis bit j.
    function automatic logic [7:0] map_mat(input logic [63:0] m, input logic [7:0] v);
        logic [7:0] acc;
        acc = 8'h00;
        for (int j = 0; j < 8; j++)
            if (v[j]) acc = acc ^ m[8*j +: 8];
        return acc;
    endfunction

    // Elaboration-time search for a root of x^8+x^4+x^3+x+1 in the tower field.
    function automatic logic [7:0] find_root();
        logic [7:0] b, b2, b4, b8, root;
        root = 8'h00;
        for (int i = 255; i >= 2; i--) begin
            b  = 8'(i);
            b2 = gfc_mul(b, b);
            b4 = gfc_mul(b2, b2);
            b8 = gfc_mul(b4, b4);
            if ((b8 ^ b4 ^ gfc_mul(b2, b) ^ b ^ 8'h01) == 8'h00)
                root = b;
        end
        return root;
    endfunction

    function automatic logic [63:0] build_fwd(input logic [7:0] root);
        logic [63:0] m;
        logic [7:0]  p;
        p = 8'h01;
        m = '0;
        m[7:0] = p;
        for (int j = 1; j < 8; j++) begin
            p = gfc_mul(p, root);
            m[8*j +: 8] = p;
        end
        return m;
    endfunction

    function automatic logic [63:0] build_inv(input logic [63:0] fwd);
        logic [63:0] m;
        logic [7:0]  c;
        m = '0;
        for (int p = 1; p < 256; p++) begin
            c = map_mat(fwd, 8'(p));
            for (int k = 0; k < 8; k++)
                if (c == (8'h01 << k)) m[8*k +: 8] = 8'(p);
        end
        return m;
    endfunction

    localparam logic [7:0]  ROOT  = find_root();
    localparam logic [63:0] FWD_M = build_fwd(ROOT);
    localparam logic [63:0] INV_M = build_inv(FWD_M);

    logic             v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
    logic             adv1, adv2, adv3;
    logic [3:0]       ah1_q, ah1_d, al1_q, al1_d, dn1_q, dn1_d;
    logic [3:0]       e2_q, e2_d, ah2_q, ah2_d, al2_q, al2_d;
    logic [7:0]       out_data_q, out_data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       comp_byte, inv_byte, s3_byte;
    logic [3:0]       hi3, lo3;

    // A stage loads when it is empty or its contents move on this cycle.
    assign adv3     = ~v3_q | out_ready;
    assign adv2     = ~v2_q | adv3;
    assign adv1     = ~v1_q | adv2;
    assign in_ready = adv1;

    assign comp_byte = map_mat(FWD_M, in_data);
    assign hi3       = gf16_mul(e2_q, ah2_q);
    assign lo3       = hi3 ^ gf16_mul(e2_q, al2_q);
    assign inv_byte  = map_mat(INV_M, {hi3, lo3});

`ifdef SBOX_AFFINE_EN
    localparam logic [7:0] AFFINE_C = 8'h63;
    for (genvar gi = 0; gi < 8; gi++) begin : g_affine
        assign s3_byte[gi] = inv_byte[gi] ^ inv_byte[(gi + 4) % 8] ^ inv_byte[(gi + 5) % 8]
                           ^ inv_byte[(gi + 6) % 8] ^ inv_byte[(gi + 7) % 8] ^ AFFINE_C[gi];
    end
`else
    assign s3_byte = inv_byte;
`endif

    always_comb begin
        v1_d       = v1_q;
        v2_d       = v2_q;
        v3_d       = v3_q;
        ah1_d      = ah1_q;
        al1_d      = al1_q;
        dn1_d      = dn1_q;
        e2_d       = e2_q;
        ah2_d      = ah2_q;
        al2_d      = al2_q;
        out_data_d = out_data_q;
        cnt_d      = cnt_q;
        if (adv1) begin
            v1_d = in_valid;
            if (in_valid) begin
                ah1_d = comp_byte[7:4];
                al1_d = comp_byte[3:0];
                dn1_d = gf16_mul(gf16_mul(comp_byte[7:4], comp_byte[7:4]), LAMBDA)
                      ^ gf16_mul(comp_byte[7:4], comp_byte[3:0])
                      ^ gf16_mul(comp_byte[3:0], comp_byte[3:0]);
            end
        end
        if (adv2) begin
            v2_d = v1_q;
            if (v1_q) begin
                e2_d  = gf16_inv(dn1_q);
                ah2_d = ah1_q;
                al2_d = al1_q;
            end
        end
        if (adv3) begin
            v3_d = v2_q;
            if (v2_q) out_data_d = s3_byte;
        end
        if (v3_q && out_ready) cnt_d = cnt_q + 1'b1;
        if (clear) begin
            v1_d  = 1'b0;
            v2_d  = 1'b0;
            v3_d  = 1'b0;
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v1_q       <= 1'b0;
            v2_q       <= 1'b0;
            v3_q       <= 1'b0;
            out_data_q <= 8'h00;
            cnt_q      <= '0;
        end else begin
            v1_q       <= v1_d;
            v2_q       <= v2_d;
            v3_q       <= v3_d;
            out_data_q <= out_data_d;
            cnt_q      <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        ah1_q <= ah1_d;
        al1_q <= al1_d;
        dn1_q <= dn1_d;
        e2_q  <= e2_d;
        ah2_q <= ah2_d;
        al2_q <= al2_d;
    end

    assign out_valid = v3_q;
    assign out_data  = out_data_q;
    assign out_count = cnt_q;

endmodule

// File: tb/tb_gf8_inv_pipe.sv
// Directed bench for gf8_inv_pipe: latency, streaming, backpressure, clear, reset, counter wrap,
// exhaustive sweep. Expected bytes follow SBOX_AFFINE_EN when it is defined.
module tb_gf8_inv_pipe;
    localparam int TB_CNT_W = 4;

    logic                clk;
    logic                reset_n;
    logic                clear;
    logic                in_valid;
    logic                in_ready;
    logic [7:0]          in_data;
    logic                out_valid;
    logic                out_ready;
    logic [7:0]          out_data;
    logic [TB_CNT_W-1:0] out_count;

    int         checks = 0;
    int         errors = 0;
    int         hs_cnt = 0;
    logic       hold_pending = 1'b0;
    logic [7:0] held_data = 8'h00;
    logic [7:0] ref_tab [256];
    logic [7:0] exp_q [$];

`ifdef SBOX_AFFINE_EN
    logic [7:0] e53 = 8'hED;
    logic [7:0] e02 = 8'h77;
    logic [7:0] vout [4] = '{8'h63, 8'h7C, 8'hED, 8'h74};
`else
    logic [7:0] e53 = 8'hCA;
    logic [7:0] e02 = 8'h8D;
    logic [7:0] vout [4] = '{8'h00, 8'h01, 8'hCA, 8'h53};
`endif
    logic [7:0] vin [4] = '{8'h00, 8'h01, 8'h53, 8'hCA};
    logic [7:0] din [5] = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h06};

    gf8_inv_pipe #(.CNT_W(TB_CNT_W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached, observed=running required=finished");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1B) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] affine(input logic [7:0] b);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    // Called at a negedge: scoreboard the handshakes of the coming edge, then step past it.
    task automatic edge_();
        logic [7:0] e;
        if (hold_pending)
            check("hold_stable", 32'({out_valid, out_data}), 32'({1'b1, held_data}));
        if (clear) begin
            exp_q.delete();
            hs_cnt       = 0;
            hold_pending = 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out", 32'(out_valid), 32'(1'b0));
                end else begin
                    e = exp_q.pop_front();
                    $display("txn %0d: out_data=%02h ref=%02h", hs_cnt, out_data, e);
                    check("out_data", 32'(out_data), 32'(e));
                end
                hs_cnt++;
            end
            hold_pending = out_valid && !out_ready;
            held_data    = out_data;
            if (in_valid && in_ready) exp_q.push_back(ref_tab[in_data]);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cyc();
        neg();
        edge_();
    endtask

    initial begin
        int v, k, budget;
        logic acc;

        for (int a = 0; a < 256; a++) ref_tab[a] = 8'h00;
        for (int a = 1; a < 256; a++)
            for (int b = 1; b < 256; b++)
                if (gmul(8'(a), 8'(b)) == 8'h01) ref_tab[a] = 8'(b);
`ifdef SBOX_AFFINE_EN
        for (int a = 0; a < 256; a++) ref_tab[a] = affine(ref_tab[a]);
`endif

        // Reset state, observed before any clock edge
        reset_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
        #3;
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_out_data", 32'(out_data), 32'(0));
        check("rst_out_count", 32'(out_count), 32'(0));
        @(posedge clk); @(posedge clk); #1;
        reset_n = 1'b1;

        // Single byte: latency exactly 3 cycles
        in_valid = 1'b1; in_data = 8'h53; out_ready = 1'b1;
        neg(); check("rdy_after_reset", 32'(in_ready), 32'(1)); edge_();
        in_valid = 1'b0;
        neg(); check("lat1_valid", 32'(out_valid), 32'(0)); edge_();
        neg(); check("lat2_valid", 32'(out_valid), 32'(0)); edge_();
        neg(); check("lat3_valid", 32'(out_valid), 32'(1));
        check("x53_data", 32'(out_data), 32'(e53)); edge_();
        neg(); check("x53_count", 32'(out_count), 32'(1)); edge_();

        // Back-to-back stream, results on consecutive cycles
        for (int c = 0; c < 7; c++) begin
            in_valid = (c < 4);
            if (c < 4) in_data = vin[c];
            neg();
            if (c >= 3) begin
                check("stream_valid", 32'(out_valid), 32'(1));
                check("stream_data", 32'(out_data), 32'(vout[c-3]));
            end
            edge_();
        end
        in_valid = 1'b0;

        // Backpressure: 5 offered, 3 accepted
        out_ready = 1'b0; in_valid = 1'b1; k = 0;
        for (int c = 0; c < 6; c++) begin
            in_data = din[(k < 5) ? k : 4];
            neg();
            acc = in_ready;
            edge_();
            if (acc) k++;
        end
        check("bp_accepted", 32'(k), 32'(3));
        neg();
        check("bp_in_ready", 32'(in_ready), 32'(0));
        check("bp_head_data", 32'(out_data), 32'(e02));
        edge_();
        in_valid = 1'b0; out_ready = 1'b1;
        cyc(); cyc(); cyc();
        neg();
        check("bp_drained_valid", 32'(out_valid), 32'(0));
        check("bp_count", 32'(out_count), 32'(8));
        edge_();

        // Clear with 3 in flight plus a simultaneous offer and output handshake
        out_ready = 1'b0; in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            in_data = 8'(8'h11 * (c + 1));
            cyc();
        end
        in_data = 8'h44; out_ready = 1'b1; clear = 1'b1;
        cyc();
        clear = 1'b0; in_valid = 1'b0;
        neg();
        check("clr_out_valid", 32'(out_valid), 32'(0));
        check("clr_out_count", 32'(out_count), 32'(0));
        check("clr_in_ready", 32'(in_ready), 32'(1));
        edge_();
        for (int c = 0; c < 5; c++) begin
            neg(); check("clr_no_stale", 32'(out_valid), 32'(0)); edge_();
        end

        // Counter wrap: 17 handshakes with a 4-bit counter
        for (int i = 0; i < 17; i++) begin
            in_valid = 1'b1; in_data = 8'(8'h20 + i);
            cyc();
        end
        in_valid = 1'b0;
        cyc(); cyc(); cyc(); cyc();
        neg();
        check("wrap_count", 32'(out_count), 32'(1));
        check("wrap_drained", 32'(exp_q.size()), 32'(0));
        edge_();

        // Asynchronous reset with the pipeline full
        out_ready = 1'b0; in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            in_data = 8'(8'h70 + c);
            cyc();
        end
        in_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'(0));
        check("midrst_out_data", 32'(out_data), 32'(0));
        check("midrst_out_count", 32'(out_count), 32'(0));
        exp_q.delete(); hs_cnt = 0; hold_pending = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        reset_n = 1'b1; out_ready = 1'b1;
        neg(); check("midrst_in_ready", 32'(in_ready), 32'(1)); edge_();
        for (int c = 0; c < 5; c++) begin
            neg(); check("midrst_no_stale", 32'(out_valid), 32'(0)); edge_();
        end

        // Exhaustive sweep with random backpressure
        v = 0; budget = 0; in_valid = 1'b1; in_data = 8'h00;
        while (v < 256 && budget < 4000) begin
            out_ready = 1'($urandom_range(0, 1));
            neg();
            acc = in_ready;
            edge_();
            if (acc) v++;
            in_data  = 8'(v);
            in_valid = (v < 256);
            budget++;
        end
        in_valid = 1'b0;
        check("exh_all_accepted", 32'(v), 32'(256));
        out_ready = 1'b1; budget = 0;
        while (exp_q.size() > 0 && budget < 20) begin
            cyc();
            budget++;
        end
        check("exh_drained", 32'(exp_q.size()), 32'(0));
        neg();
        check("exh_count", 32'(out_count), 32'(hs_cnt % (1 << TB_CNT_W)));
        edge_();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
